// File: rtl/spawn_scheduler.sv
// Tick-driven spawn scheduler: picks a free lane round-robin, throttled by a random density
// test and per-lane cooldowns. Define SPAWN_STATS_EN to add the spawn_count output.
module spawn_scheduler #(
    parameter int         NUM_LANES = 4,
    parameter logic [7:0] DENSITY   = 8'h80,
    parameter int         MIN_GAP   = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [15:0]          rand_in,
    input  logic [NUM_LANES-1:0] lane_busy,
    output logic                 spawn_valid,
    input  logic                 spawn_ready,
    output logic [2:0]           spawn_lane,
    output logic [2:0]           spawn_speed,
    output logic                 spawn_dir,
    output logic                 tick_dropped
`ifdef SPAWN_STATS_EN
    ,
    output logic [15:0]          spawn_count
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, ISSUE} state_t;

    state_t state_reg, state_next;

    logic [15:0]            rand_q_reg;
    logic [2:0]             rr_ptr_reg;
    logic                   spawn_valid_reg;
    logic [2:0]             spawn_lane_reg;
    logic [2:0]             spawn_speed_reg;
    logic                   spawn_dir_reg;
    logic                   tick_dropped_reg;

    logic [NUM_LANES-1:0]   eligible;
    logic [2*NUM_LANES-1:0] elig_dbl;
    logic [NUM_LANES-1:0]   elig_rot;
    logic [NUM_LANES-1:0]   first_hot;
    logic [2:0][NUM_LANES-1:0] enc_bits;
    logic [2:0]             grant_off;
    logic [3:0]             grant_sum;
    logic [2:0]             grant;
    logic                   density_ok;
    logic                   grant_ok;
    logic                   accept;
    logic [2:0]             lane_inc;
    logic                   rand_unused;

    assign rand_unused = ^rand_q_reg[15:11];

    assign accept     = (state_reg == ISSUE) && spawn_valid_reg && spawn_ready;
    assign density_ok = rand_q_reg[7:0] < DENSITY;

    // Rotate eligibility so that bit 0 corresponds to rr_ptr; the lowest set bit then
    // gives the offset of the winning lane from the round-robin pointer.
    assign elig_dbl = {eligible, eligible};
    assign elig_rot = NUM_LANES'(elig_dbl >> rr_ptr_reg);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gen_lane
            localparam logic [NUM_LANES-1:0] LOW_MASK = NUM_LANES'((1 << gi) - 1);
            logic [3:0] cooldown_reg;

            always_ff @(posedge clock) begin
                if (reset) begin
                    cooldown_reg <= 4'd0;
                end else if (accept && (spawn_lane_reg == 3'(gi))) begin
                    cooldown_reg <= 4'(MIN_GAP);
                end else if (tick && (cooldown_reg != 4'd0)) begin
                    cooldown_reg <= cooldown_reg - 4'd1;
                end
            end

            assign eligible[gi]  = (cooldown_reg == 4'd0) && !lane_busy[gi];
            assign first_hot[gi] = elig_rot[gi] && ((elig_rot & LOW_MASK) == '0);

            for (genvar bi = 0; bi < 3; bi++) begin : gen_enc
                assign enc_bits[bi][gi] = first_hot[gi] && (((gi >> bi) & 1) == 1);
            end
        end
    endgenerate

    assign grant_off[0] = |enc_bits[0];
    assign grant_off[1] = |enc_bits[1];
    assign grant_off[2] = |enc_bits[2];

    assign grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
    assign grant     = (grant_sum >= 4'(NUM_LANES)) ? 3'(grant_sum - 4'(NUM_LANES))
                                                    : grant_sum[2:0];
    assign grant_ok  = density_ok && (|eligible);
    assign lane_inc  = spawn_lane_reg + 3'd1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (tick) state_next = EVAL;
            EVAL:    state_next = grant_ok ? ISSUE : IDLE;
            ISSUE:   if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rand_q_reg       <= 16'd0;
            rr_ptr_reg       <= 3'd0;
            spawn_valid_reg  <= 1'b0;
            spawn_lane_reg   <= 3'd0;
            spawn_speed_reg  <= 3'd0;
            spawn_dir_reg    <= 1'b0;
            tick_dropped_reg <= 1'b0;
        end else begin
            tick_dropped_reg <= tick && (state_reg != IDLE);
            if ((state_reg == IDLE) && tick) begin
                rand_q_reg <= rand_in;
            end
            if ((state_reg == EVAL) && grant_ok) begin
                spawn_valid_reg <= 1'b1;
                spawn_lane_reg  <= grant;
                spawn_speed_reg <= {1'b0, rand_q_reg[9:8]} + 3'd1;
                spawn_dir_reg   <= rand_q_reg[10];
            end else if (accept) begin
                // Lane/speed/dir keep their last values; only valid drops.
                spawn_valid_reg <= 1'b0;
                rr_ptr_reg      <= (lane_inc == 3'(NUM_LANES)) ? 3'd0 : lane_inc;
            end
        end
    end

`ifdef SPAWN_STATS_EN
    logic [15:0] spawn_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            spawn_count_reg <= 16'd0;
        end else if (accept && (spawn_count_reg != 16'hFFFF)) begin
            spawn_count_reg <= spawn_count_reg + 16'd1;
        end
    end

    assign spawn_count = spawn_count_reg;
`endif

    assign spawn_valid  = spawn_valid_reg;
    assign spawn_lane   = spawn_lane_reg;
    assign spawn_speed  = spawn_speed_reg;
    assign spawn_dir    = spawn_dir_reg;
    assign tick_dropped = tick_dropped_reg;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed bench for spawn_scheduler: a transaction-level model predicts every output each
// cycle, and literal expectations pin the key scenarios (grant order, hold, cooldown, reset).
module tb_spawn_scheduler;

    localparam int         NL   = 4;
    localparam logic [7:0] DENS = 8'h80;
    localparam int         GAP  = 3;

    logic        clock;
    logic        reset;
    logic        tick;
    logic [15:0] rand_in;
    logic [NL-1:0] lane_busy;
    logic        spawn_valid;
    logic        spawn_ready;
    logic [2:0]  spawn_lane;
    logic [2:0]  spawn_speed;
    logic        spawn_dir;
    logic        tick_dropped;
`ifdef SPAWN_STATS_EN
    logic [15:0] spawn_count;
`endif

    spawn_scheduler #(.NUM_LANES(NL), .DENSITY(DENS), .MIN_GAP(GAP)) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .rand_in      (rand_in),
        .lane_busy    (lane_busy),
        .spawn_valid  (spawn_valid),
        .spawn_ready  (spawn_ready),
        .spawn_lane   (spawn_lane),
        .spawn_speed  (spawn_speed),
        .spawn_dir    (spawn_dir),
        .tick_dropped (tick_dropped)
`ifdef SPAWN_STATS_EN
        ,
        .spawn_count  (spawn_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model state: what the scheduler has promised, not how it is built.
    bit          m_pending;
    bit          m_valid;
    int          m_lane, m_speed, m_dir, m_drop, m_rr, m_count;
    int          m_cd[NL];
    logic [15:0] m_rand;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_valid = 0; m_lane = 0; m_speed = 0; m_dir = 0;
        m_drop = 0; m_rr = 0; m_count = 0; m_rand = 16'h0;
        for (int i = 0; i < NL; i++) m_cd[i] = 0;
    endtask

    task automatic model_step();
        int  ncd[NL];
        bit  acc, found, dropped;
        int  lane;
        if (reset) begin
            model_reset();
            return;
        end
        dropped = tick && (m_pending || m_valid);
        acc     = m_valid && spawn_ready;
        for (int i = 0; i < NL; i++) ncd[i] = (tick && m_cd[i] > 0) ? m_cd[i] - 1 : m_cd[i];
        if (m_pending) begin
            m_pending = 0;
            found = 0;
            if (m_rand[7:0] < DENS) begin
                for (int k = 0; k < NL; k++) begin
                    lane = (m_rr + k) % NL;
                    if (!found && m_cd[lane] == 0 && lane_busy[lane] == 1'b0) begin
                        found  = 1;
                        m_lane = lane;
                    end
                end
            end
            if (found) begin
                m_valid = 1;
                m_speed = int'(m_rand[9:8]) + 1;
                m_dir   = int'(m_rand[10]);
            end
        end else if (acc) begin
            ncd[m_lane] = GAP;
            m_valid     = 0;
            m_rr        = (m_lane + 1) % NL;
            if (m_count < 16'hFFFF) m_count++;
            $display("spawn accepted: lane=%0d speed=%0d dir=%0d t=%0t", m_lane, m_speed, m_dir, $time);
        end else if (!m_valid && tick) begin
            m_rand    = rand_in;
            m_pending = 1;
        end
        for (int i = 0; i < NL; i++) m_cd[i] = ncd[i];
        m_drop = dropped;
    endtask

    task automatic compare_outputs();
        check("spawn_valid",  spawn_valid,  m_valid);
        check("spawn_lane",   spawn_lane,   m_lane);
        check("spawn_speed",  spawn_speed,  m_speed);
        check("spawn_dir",    spawn_dir,    m_dir);
        check("tick_dropped", tick_dropped, m_drop);
`ifdef SPAWN_STATS_EN
        check("spawn_count",  spawn_count,  m_count);
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare at negedge.
    task automatic cyc(input logic t, input logic [15:0] r, input logic [NL-1:0] b,
                       input logic rdy, input logic rs);
        tick = t; rand_in = r; lane_busy = b; spawn_ready = rdy; reset = rs;
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_outputs();
    endtask

    int exp_seq[4] = '{0, 2, 3, 0};

    initial begin
        model_reset();
        tick = 0; rand_in = 0; lane_busy = 0; spawn_ready = 0; reset = 1;

        // Reset state
        cyc(0, 16'h0, 4'b0, 1, 1);
        cyc(0, 16'h0, 4'b0, 1, 1);
        check("reset_valid", spawn_valid, 0);
        check("reset_speed", spawn_speed, 0);

        // Basic spawn: lane 0, speed 2, dir 1, two cycles after the tick
        cyc(1, 16'h0510, 4'b0, 1, 0);
        check("lat_not_yet", spawn_valid, 0);
        cyc(0, 16'h0, 4'b0, 1, 0);
        check("basic_valid", spawn_valid, 1);
        check("basic_lane",  spawn_lane,  0);
        check("basic_speed", spawn_speed, 2);
        check("basic_dir",   spawn_dir,   1);
        cyc(0, 16'h0, 4'b0, 1, 0);
        check("basic_drop_valid", spawn_valid, 0);
        // rr_ptr moved to 1
        cyc(1, 16'h0003, 4'b0, 1, 0);
        cyc(0, 16'h0, 4'b0, 1, 0);
        check("rr_next_lane",  spawn_lane,  1);
        check("rr_next_speed", spawn_speed, 1);
        cyc(0, 16'h0, 4'b0, 1, 0);

        // Density boundary: 8'h80 is not below DENSITY
        cyc(1, 16'h0080, 4'b0, 1, 0);
        cyc(0, 16'h0, 4'b0, 1, 0);
        check("density_block", spawn_valid, 0);
        cyc(1, 16'h067F, 4'b0, 1, 0);
        cyc(0, 16'h0, 4'b0, 1, 0);
        check("density_pass", spawn_valid, 1);
        check("density_lane", spawn_lane,  2);
        cyc(0, 16'h0, 4'b0, 1, 0);

        // Backpressure hold, dropped ticks, accept+tick, load-wins cooldown
        cyc(0, 16'h0, 4'b0, 1, 1);
        cyc(1, 16'h0000, 4'b0, 0, 0);
        cyc(0, 16'h0, 4'b0, 0, 0);
        for (int j = 0; j < 5; j++) begin
            cyc(logic'(j % 2 == 0), 16'h00FF, 4'b0, 0, 0);
            check("hold_valid", spawn_valid, 1);
            check("hold_lane",  spawn_lane,  0);
            check("hold_speed", spawn_speed, 1);
            check("hold_dir",   spawn_dir,   0);
            check("hold_drop",  tick_dropped, (j % 2 == 0) ? 1 : 0);
        end
        cyc(1, 16'h0, 4'b0, 1, 0);
        check("accept_tick_valid", spawn_valid, 0);
        check("accept_tick_drop",  tick_dropped, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 16'h0000, 4'b1110, 1, 0);
            cyc(0, 16'h0, 4'b1110, 1, 0);
            check("cooldown_gate", spawn_valid, (k == 2) ? 1 : 0);
        end
        check("cooldown_lane", spawn_lane, 0);
        cyc(0, 16'h0, 4'b1110, 1, 0);

        // Round-robin with lane 1 busy: 0, 2, 3, then 0 after cooldown expires
        cyc(0, 16'h0, 4'b0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 16'h0000, 4'b0010, 1, 0);
            cyc(0, 16'h0, 4'b0010, 1, 0);
            check("rr_seq_valid", spawn_valid, 1);
            check("rr_seq_lane",  spawn_lane,  exp_seq[k]);
            cyc(0, 16'h0, 4'b0010, 1, 0);
        end

        // Reset while a spawn is pending beats tick and ready
        cyc(0, 16'h0, 4'b0, 1, 1);
        cyc(1, 16'h0000, 4'b0, 1, 0);
        cyc(0, 16'h0, 4'b0, 1, 0);
        cyc(0, 16'h0, 4'b0, 1, 0);
        cyc(1, 16'h0000, 4'b0, 0, 0);
        cyc(0, 16'h0, 4'b0, 0, 0);
        check("pre_reset_lane", spawn_lane, 1);
        cyc(1, 16'h0, 4'b0, 1, 1);
        check("reset_kill_valid", spawn_valid, 0);
        check("reset_kill_drop",  tick_dropped, 0);
        cyc(1, 16'h0000, 4'b0, 1, 0);
        cyc(0, 16'h0, 4'b0, 1, 0);
        check("post_reset_valid", spawn_valid, 1);
        check("post_reset_lane",  spawn_lane,  0);
        cyc(0, 16'h0, 4'b0, 1, 0);
`ifdef SPAWN_STATS_EN
        for (int k = 0; k < 2; k++) begin
            cyc(1, 16'h0000, 4'b0, 1, 0);
            cyc(0, 16'h0, 4'b0, 1, 0);
            cyc(0, 16'h0, 4'b0, 1, 0);
        end
        check("stats_three", spawn_count, 3);
        cyc(0, 16'h0, 4'b0, 1, 1);
        check("stats_reset", spawn_count, 0);
`endif
        cyc(0, 16'h0, 4'b0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of traffic lanes competing for spawns (2..8).
REQ-002 SHALL have parameter DENSITY, default 8'h80: a spawn is allowed when rand byte < DENSITY.
REQ-003 SHALL have parameter MIN_GAP, default 3: ticks a lane is blocked after an accepted spawn (1..15).
REQ-004 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tick  input  1  one-cycle game-tick pulse.
REQ-007 SHALL have port rand_in  input  16  current value of the free-running random generator.
REQ-008 SHALL have port lane_busy  input  NUM_LANES  lane occupied at its spawn point; bit i = lane i.
REQ-009 SHALL have port spawn_valid  output  1  spawn request pending.
REQ-010 SHALL have port spawn_ready  input  1  object pool accepts the spawn.
REQ-011 SHALL have port spawn_lane  output  3  granted lane index.
REQ-012 SHALL have port spawn_speed  output  3  object speed, 1..4.
REQ-013 SHALL have port spawn_dir  output  1  0 = leftward, 1 = rightward.
REQ-014 SHALL have port tick_dropped  output  1  one-cycle pulse when a tick arrives outside IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EVAL, ISSUE.
REQ-016 IDLE: on tick, SHALL latch rand_in into rand_q and go to EVAL; otherwise stay.
REQ-017 EVAL: eligible lane = cooldown==0 and lane_busy==0, with lane_busy sampled this cycle.
REQ-018 EVAL: if rand_q[7:0] < DENSITY and any lane is eligible, SHALL grant the first eligible lane searching upward from rr_ptr with wrap, then go to ISSUE; otherwise go to IDLE with no output.
REQ-019 On entering ISSUE, registered outputs SHALL be spawn_lane = grant, spawn_speed = rand_q[9:8]+1, spawn_dir = rand_q[10], spawn_valid = 1; latency tick -> spawn_valid is exactly 2 cycles.
REQ-020 ISSUE: spawn_valid, spawn_lane, spawn_speed, spawn_dir SHALL stay stable until the cycle where spawn_valid && spawn_ready.
REQ-021 On accept: SHALL drop spawn_valid next cycle, load that lane's cooldown with MIN_GAP, set rr_ptr = (lane+1) mod NUM_LANES, go to IDLE.
REQ-022 Each lane's 4-bit cooldown SHALL decrement by 1 on every tick in any state, saturating at 0.
REQ-023 If an accept and a tick occur in the same cycle, that lane's cooldown SHALL be loaded with MIN_GAP (load wins over decrement).
REQ-024 A tick in EVAL or ISSUE SHALL NOT start a new evaluation and SHALL pulse tick_dropped for one cycle; cooldowns still decrement.
REQ-025 A tick in the same cycle an accept returns the FSM to IDLE SHALL count as dropped.
REQ-026 rr_ptr SHALL change only on an accept.

Reset
REQ-027 Reset SHALL force state IDLE, rr_ptr = 0, all cooldowns = 0, rand_q = 0, spawn_valid = 0, spawn_lane = 0, spawn_speed = 0, spawn_dir = 0, tick_dropped = 0.
REQ-028 Reset asserted in ISSUE SHALL deassert spawn_valid on the next edge, with no cooldown load and no rr_ptr update.
REQ-029 Reset SHALL take priority over tick and spawn_ready in the same cycle.

Configuration
REQ-030 With macro SPAWN_STATS_EN defined, SHALL add output spawn_count [15:0]: counts accepted spawns, resets to 0, saturates at 16'hFFFF.
REQ-031 Without SPAWN_STATS_EN, the spawn_count port and its counter SHALL NOT exist; all other behaviour is identical.

Verification (NUM_LANES=4, DENSITY=8'h80, MIN_GAP=3)
REQ-032 Reset; tick with rand_in=16'h0510, lane_busy=0, spawn_ready=1 -> 2 cycles later spawn_valid=1, lane 0, speed 2, dir 1, for 1 cycle; rr_ptr becomes 1.
REQ-033 Tick with rand_in[7:0]=8'h80 -> no spawn_valid, FSM back in IDLE after EVAL.
REQ-034 spawn_ready=0 for 5 cycles after spawn_valid -> outputs held constant for 5 cycles; accepted on the 6th; extra ticks in this window each pulse tick_dropped.
REQ-035 Four successful spawns with lane_busy=4'b0010 -> lanes granted 0, 2, 3, then 0 only once its cooldown has expired (3 ticks); lane 1 never granted.
REQ-036 Reset asserted while spawn_valid=1 and spawn_ready=0 -> spawn_valid=0 next cycle; next spawn grants lane 0.
REQ-037 With SPAWN_STATS_EN, 3 accepted spawns -> spawn_count=3; after reset, spawn_count=0.
